gpu_framebuffer_writer: RTL and testbench

Pixel sink for the GPU core: accepts the (x, y, r, g, b) stream produced by the line/fill output path, computes a linear framebuffer address, buffers pixels in a small FIFO, and writes each one to framebuffer memory over a req/ack handshake. It sits directly downstream of the output decoder and colour path in `gpu`. It replaces the direct `x_o/y_o/r_o/g_o/b_o` outputs with a memory-write port and adds backpressure toward the draw engines.

---
 rtl/gpu_pkg.sv | 23 ++
 rtl/gpu_pixel_fifo.sv | 53 +++++
 rtl/gpu_framebuffer_writer.sv | 118 +++++++++++
 tb/tb_gpu_framebuffer_writer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared constants and types for the GPU pixel output path.
//   Screen geometry and coordinate/colour widths, the queued pixel record
//   and the framebuffer writer FSM state encoding.
package gpu_pkg;
  localparam int WIDTH_BITS    = 10;
  localparam int HEIGHT_BITS   = 9;
  localparam int CHANNEL_BITS  = 8;
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int ADDR_BITS     = WIDTH_BITS + HEIGHT_BITS;

  typedef struct packed {
    logic [ADDR_BITS-1:0]    addr;
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
  } pixel_t;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_REQ  = 1'b1
  } wr_state_e;
endpackage

// File: rtl/gpu_pixel_fifo.sv
// gpu_pixel_fifo: parameterised synchronous FIFO (DEPTH power of two, >= 2).
//   clk, rst (sync active-high), push_i/din_i, pop_i, dout_o (head, combinational
//   read), full_o, empty_o, count_o. Push while full and pop while empty are ignored.
module gpu_pixel_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/gpu_framebuffer_writer.sv
// gpu_framebuffer_writer: pixel sink that range-checks incoming (x,y,r,g,b),
//   computes the linear framebuffer address, queues pixels and writes them to
//   memory over a req/ack handshake.
//   In : clk, n_rst (sync, active-high), pixel_valid_i, x_i, y_i, r_i, g_i, b_i,
//        mem_ack_i
//   Out: pixel_ready_o, mem_req_o, mem_addr_o, mem_wdata_o ({r,g,b}), busy_o,
//        drop_count_o (saturating count of off-screen pixels)
module gpu_framebuffer_writer
  import gpu_pkg::*;
#(
  parameter int SCREEN_WIDTH  = gpu_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = gpu_pkg::SCREEN_HEIGHT,
  parameter int WIDTH_BITS    = gpu_pkg::WIDTH_BITS,
  parameter int HEIGHT_BITS   = gpu_pkg::HEIGHT_BITS,
  parameter int CHANNEL_BITS  = gpu_pkg::CHANNEL_BITS,
  parameter int FIFO_DEPTH    = 4,
  parameter int ADDR_BITS     = WIDTH_BITS + HEIGHT_BITS
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      pixel_valid_i,
  input  logic [WIDTH_BITS-1:0]     x_i,
  input  logic [HEIGHT_BITS-1:0]    y_i,
  input  logic [CHANNEL_BITS-1:0]   r_i,
  input  logic [CHANNEL_BITS-1:0]   g_i,
  input  logic [CHANNEL_BITS-1:0]   b_i,
  output logic                      pixel_ready_o,
  output logic                      mem_req_o,
  output logic [ADDR_BITS-1:0]      mem_addr_o,
  output logic [3*CHANNEL_BITS-1:0] mem_wdata_o,
  input  logic                      mem_ack_i,
  output logic                      busy_o,
  output logic [15:0]               drop_count_o
);
  localparam int DATA_W = 3 * CHANNEL_BITS;
  localparam int PIX_W  = ADDR_BITS + DATA_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic                 in_range, accept, push, pop;
  logic [ADDR_BITS-1:0] addr_calc;
  logic [PIX_W-1:0]     fifo_dout;
  logic                 fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  wr_state_e            state_q;
  logic                 req_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [15:0]          drop_q, drop_d;

  // No pop-through: a full FIFO refuses input even on a popping edge.
  assign pixel_ready_o = !fifo_full;
  assign accept        = pixel_valid_i && pixel_ready_o;
  assign in_range      = (int'(x_i) < SCREEN_WIDTH) && (int'(y_i) < SCREEN_HEIGHT);
  assign push          = accept && in_range;
  assign addr_calc     = ADDR_BITS'(y_i) * ADDR_BITS'(SCREEN_WIDTH) + ADDR_BITS'(x_i);

  // Refill the output registers whenever they are free: in IDLE, or on the
  // ack edge in REQ so back-to-back writes run at one per cycle.
  assign pop = !fifo_empty && ((state_q == WR_IDLE) || mem_ack_i);

  gpu_pixel_fifo #(.DATA_W(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (n_rst),
    .push_i (push),
    .din_i  ({addr_calc, r_i, g_i, b_i}),
    .pop_i  (pop),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= WR_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        WR_IDLE: if (!fifo_empty) begin
          {addr_q, wdata_q} <= fifo_dout;
          req_q   <= 1'b1;
          state_q <= WR_REQ;
        end
        WR_REQ: if (mem_ack_i) begin
          if (!fifo_empty) begin
            {addr_q, wdata_q} <= fifo_dout;
          end else begin
            req_q   <= 1'b0;
            state_q <= WR_IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= WR_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (accept && !in_range && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (n_rst) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign mem_req_o    = req_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign busy_o       = (fifo_count != '0) || (state_q == WR_REQ);
  assign drop_count_o = drop_q;
endmodule

// File: tb/tb_gpu_framebuffer_writer.sv
module tb_gpu_framebuffer_writer;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        pixel_valid_i = 1'b0;
  logic [9:0]  x_i = '0;
  logic [8:0]  y_i = '0;
  logic [7:0]  r_i = '0, g_i = '0, b_i = '0;
  logic        pixel_ready_o, mem_req_o, mem_ack_i = 1'b0, busy_o;
  logic [18:0] mem_addr_o;
  logic [23:0] mem_wdata_o;
  logic [15:0] drop_count_o;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int drop_m = 0;
  pixel_t exp_q[$];
  pixel_t p;

  always #5 clk = ~clk;

  gpu_framebuffer_writer dut (
    .clk(clk), .n_rst(n_rst), .pixel_valid_i(pixel_valid_i),
    .x_i(x_i), .y_i(y_i), .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .pixel_ready_o(pixel_ready_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .busy_o(busy_o), .drop_count_o(drop_count_o)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int x, input int y, input logic [23:0] rgb);
    pixel_valid_i = 1'b1;
    x_i = 10'(x); y_i = 9'(y);
    {r_i, g_i, b_i} = rgb;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy_o && n < max) begin tick(); n++; end
    chk("drain_timeout_busy", busy_o, 0);
  endtask

  // Reference model: every accepted on-screen pixel must appear exactly once,
  // in order, as an acknowledged write at y*640+x with {r,g,b}.
  always @(negedge clk) begin
    if (n_rst) begin
      exp_q.delete();
      drop_m = 0;
    end else begin
      if (mem_req_o && mem_ack_i) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          p = exp_q.pop_front();
          chk("wr_addr", mem_addr_o, p.addr);
          chk("wr_data", mem_wdata_o, {p.r, p.g, p.b});
        end
      end
      if (pixel_valid_i && pixel_ready_o) begin
        if (x_i < 640 && y_i < 480) begin
          p.addr = 19'(int'(y_i) * 640 + int'(x_i));
          p.r = r_i; p.g = g_i; p.b = b_i;
          exp_q.push_back(p);
        end else if (drop_m != 65535) drop_m++;
      end
    end
  end

  typedef struct {
    int          x, y;
    logic [23:0] rgb;
    bit          on;
    int          addr;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int acc, w0, run, maxrun, total;
    vecs[0] = '{0, 0, 24'hA1B2C3, 1'b1, 0};
    vecs[1] = '{639, 479, 24'hFFFFFF, 1'b1, 307199};
    vecs[2] = '{3, 2, 24'h112233, 1'b1, 1283};
    vecs[3] = '{640, 0, 24'h010203, 1'b0, 0};
    vecs[4] = '{0, 480, 24'h040506, 1'b0, 0};
    vecs[5] = '{1023, 511, 24'h070809, 1'b0, 0};
    vecs[6] = '{639, 0, 24'h5A5A5A, 1'b1, 639};
    vecs[7] = '{0, 1, 24'h00FF00, 1'b1, 640};

    // Reset values
    tick();
    chk("rst_ready", pixel_ready_o, 1);
    chk("rst_req", mem_req_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_drop", drop_count_o, 0);
    n_rst = 1'b0;
    tick();

    // Single pixel, ack one cycle after req
    drive(3, 2, 24'h112233);
    tick();
    pixel_valid_i = 1'b0;
    chk("single_no_bypass", mem_req_o, 0);
    chk("single_busy_queued", busy_o, 1);
    tick();
    chk("single_req", mem_req_o, 1);
    chk("single_addr", mem_addr_o, 1283);
    chk("single_wdata", mem_wdata_o, 24'h112233);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    chk("single_req_drop", mem_req_o, 0);
    chk("single_busy_clear", busy_o, 0);

    // Backpressure: ack held low, offer 6 pixels
    acc = 0;
    w0 = wr_cnt;
    for (int i = 0; i < 6; i++) begin
      drive(10 + i, 5, {8'(i), 8'(i * 3), 8'(i * 7)});
      if (pixel_ready_o) acc++;
      tick();
    end
    pixel_valid_i = 1'b0;
    chk("bp_accepts", acc, 5);
    chk("bp_ready_low", pixel_ready_o, 0);
    mem_ack_i = 1'b1;
    wait_idle(30);
    mem_ack_i = 1'b0;
    chk("bp_writes", wr_cnt - w0, 5);
    chk("bp_ready_back", pixel_ready_o, 1);

    // Back-to-back with ack tied high
    mem_ack_i = 1'b1;
    run = 0; maxrun = 0; total = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drive(100 + i * 9, 20 + i, {8'(i), 8'hC0, 8'(255 - i)});
      else pixel_valid_i = 1'b0;
      tick();
      if (mem_req_o) begin run++; total++; end else run = 0;
      if (run > maxrun) maxrun = run;
    end
    mem_ack_i = 1'b0;
    chk("b2b_req_cycles", total, 8);
    chk("b2b_consecutive", maxrun, 8);
    chk("b2b_queue_empty", exp_q.size(), 0);

    // Table-driven single pixels (incl. corner address and off-screen)
    foreach (vecs[k]) begin
      drive(vecs[k].x, vecs[k].y, vecs[k].rgb);
      tick();
      pixel_valid_i = 1'b0;
      tick();
      chk($sformatf("vec%0d_req", k), mem_req_o, vecs[k].on);
      if (vecs[k].on) begin
        chk($sformatf("vec%0d_addr", k), mem_addr_o, vecs[k].addr);
        chk($sformatf("vec%0d_wdata", k), mem_wdata_o, vecs[k].rgb);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
      end
      chk($sformatf("vec%0d_busy", k), busy_o, 0);
      chk($sformatf("vec%0d_drop", k), drop_count_o, drop_m);
    end

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      pixel_valid_i = 1'($urandom_range(1, 0));
      x_i = 10'($urandom_range(700, 0));
      y_i = 9'($urandom_range(511, 400));
      {r_i, g_i, b_i} = 24'($urandom);
      mem_ack_i = ($urandom_range(3, 0) != 0);
      tick();
    end
    pixel_valid_i = 1'b0;
    mem_ack_i = 1'b1;
    wait_idle(50);
    mem_ack_i = 1'b0;
    chk("rand_all_written", exp_q.size(), 0);
    chk("rand_drop", drop_count_o, drop_m);

    // Reset mid-request with 3 pixels queued, valid asserted during reset
    for (int i = 0; i < 4; i++) begin
      drive(i, 7, 24'hABCD00 + 24'(i));
      tick();
    end
    pixel_valid_i = 1'b0;
    chk("mid_req_before_rst", mem_req_o, 1);
    chk("mid_busy_before_rst", busy_o, 1);
    n_rst = 1'b1;
    drive(1, 1, 24'h123456);
    tick();
    n_rst = 1'b0;
    pixel_valid_i = 1'b0;
    chk("mid_rst_req", mem_req_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_ready", pixel_ready_o, 1);
    mem_ack_i = 1'b1;
    total = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_req_o || busy_o) total++;
    end
    mem_ack_i = 1'b0;
    chk("mid_rst_no_writes", total, 0);

    // Off-screen drops
    drive(640, 0, 24'h111111);
    tick();
    chk("off1_busy", busy_o, 0);
    drive(0, 480, 24'h222222);
    tick();
    pixel_valid_i = 1'b0;
    tick();
    chk("off_req", mem_req_o, 0);
    chk("off_busy", busy_o, 0);
    chk("off_drop", drop_count_o, 2);

    // Drive the drop counter to saturation, then one more
    drive(640, 0, 24'h0);
    for (int i = 0; i < 65533; i++) tick();
    pixel_valid_i = 1'b0;
    chk("sat_reach", drop_count_o, 16'hFFFF);
    drive(1000, 500, 24'h0);
    tick();
    pixel_valid_i = 1'b0;
    tick();
    chk("sat_hold", drop_count_o, 16'hFFFF);
    chk("sat_model", drop_count_o, drop_m);
    chk("sat_no_req", mem_req_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
